// File: rtl/down_counter_drain.sv
// Down-counting drain counter.
// Loads a size, then decrements x toward 0 on each enabled cycle while y counts
// the steps taken, so x + y == size at all times. Raises a one-cycle done pulse
// on entering DONE and accepts a reload from either state.
// Optional build macro DRAIN_CHECK_EN: adds a sticky err flag for invariant
// violations plus matching immediate assertions. Without it err is tied to 0.
module down_counter_drain #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SIZE_INIT = 230
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic             load,
  input  logic [WIDTH-1:0] load_size,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] size,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [0:0]       StRun    = 1'b0;
  localparam logic [0:0]       StDone   = 1'b1;
  localparam logic [WIDTH-1:0] SizeInit = WIDTH'(SIZE_INIT);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] size_q, size_d;
  logic             done_q, done_d;

  // Next-state: load beats stepping; reaching x==0 without a load moves to DONE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    size_d  = size_q;
    done_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (load) begin
          x_d    = load_size;
          size_d = load_size;
          y_d    = '0;
        end else if (x_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (selector) begin
          x_d = x_q - 1'b1;
          y_d = y_q + 1'b1;
        end
      end
      StDone: begin
        if (load) begin
          x_d     = load_size;
          size_d  = load_size;
          y_d     = '0;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State and counter registers; async reset also clears a pending done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      x_q     <= SizeInit;
      y_q     <= '0;
      size_q  <= SizeInit;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
      done_q  <= done_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign size = size_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

`ifdef DRAIN_CHECK_EN
  logic [WIDTH:0] sum_w;
  logic           bad_w;
  logic           err_q;

  // Sum at WIDTH+1 bits so a wrapped y cannot alias a correct total.
  always_comb begin
    sum_w = {1'b0, x_q} + {1'b0, y_q};
    bad_w = (sum_w != {1'b0, size_q}) || (x_q > size_q);
  end

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bad_w) begin
      err_q <= 1'b1;
    end
  end

  // Invariant checks sampled on each clock edge outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!((y_q != '0) && (y_q != size_q) && (x_q > size_q)))
        else $error("x exceeds size mid-count");
      assert (sum_w == {1'b0, size_q})
        else $error("x + y differs from size");
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_down_counter_drain.sv
// Randomized self-checking bench for down_counter_drain with a step/size
// reference model kept at the level of "steps taken out of size".
module tb_down_counter_drain;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned SIZE_INIT = 230;

  logic             clk;
  logic             rst;
  logic             selector;
  logic             load;
  logic [WIDTH-1:0] load_size;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] size;
  logic             busy;
  logic             done;
  logic             err;

  down_counter_drain #(
    .WIDTH    (WIDTH),
    .SIZE_INIT(SIZE_INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .selector (selector),
    .load     (load),
    .load_size(load_size),
    .x        (x),
    .y        (y),
    .size     (size),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: size, steps taken, finished flag, pulse flag, sticky err.
  int m_size;
  int m_steps;
  bit m_fin;
  bit m_pulse;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_size  = SIZE_INIT;
    m_steps = 0;
    m_fin   = 1'b0;
    m_pulse = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply one clock edge worth of rules to the model.
  task automatic model_edge(input bit sel, input bit ld, input int lsz);
    bit was_fin;
    was_fin = m_fin;
    m_pulse = 1'b0;
    if (ld) begin
      m_size  = lsz;
      m_steps = 0;
      m_fin   = 1'b0;
    end else if (!was_fin) begin
      if (m_size - m_steps == 0) begin
        m_fin   = 1'b1;
        m_pulse = 1'b1;
      end else if (sel) begin
        m_steps++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".x"}, 32'(x), 32'(m_size - m_steps));
    check_eq({tag, ".y"}, 32'(y), 32'(m_steps));
    check_eq({tag, ".size"}, 32'(size), 32'(m_size));
    check_eq({tag, ".busy"}, 32'(busy), 32'(!m_fin));
    check_eq({tag, ".done"}, 32'(done), 32'(m_pulse));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
    check_eq({tag, ".inv"}, 32'({1'b0, x} + {1'b0, y}), 32'({1'b0, size}));
  endtask

  // Drive at the falling edge, clock, then compare 1 time unit later.
  task automatic step(input bit sel, input bit ld, input int lsz, input string tag);
    @(negedge clk);
    selector  = sel;
    load      = ld;
    load_size = WIDTH'(lsz);
    @(posedge clk);
    model_edge(sel, ld, lsz);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and verify it acts without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst      = 1'b1;
    selector = 1'b0;
    load     = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    selector  = 1'b0;
    load      = 1'b0;
    load_size = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Full drain from the reset size.
    for (int i = 0; i < 230; i++) step(1'b1, 1'b0, 0, "drain");
    check_eq("drain.x0", 32'(x), 32'd0);
    check_eq("drain.y230", 32'(y), 32'd230);
    step(1'b1, 1'b0, 0, "enter_done");
    check_eq("enter_done.pulse", 32'(done), 32'd1);
    step(1'b1, 1'b0, 0, "post_done");
    check_eq("post_done.busy", 32'(busy), 32'd0);

    // Reset during DONE, then toggle selector.
    do_reset("rst_in_done");
    for (int i = 0; i < 8; i++) step(1'((i + 1) % 2), 1'b0, 0, "toggle");
    check_eq("toggle.x", 32'(x), 32'd226);
    check_eq("toggle.y", 32'(y), 32'd4);

    // Load beats selector in the same cycle, then drain the small size.
    do_reset("rst_b");
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 0, "pre_load");
    step(1'b1, 1'b1, 10, "load_sel");
    check_eq("load_sel.x", 32'(x), 32'd10);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 0, "small");
    check_eq("small.done", 32'(done), 32'd1);

    // Zero-size load from DONE: one RUN cycle then DONE again.
    step(1'b0, 1'b1, 0, "load_zero");
    check_eq("load_zero.busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0, 0, "zero_done");
    check_eq("zero_done.done", 32'(done), 32'd1);

    // Load while x==0 in RUN stays in RUN.
    step(1'b0, 1'b1, 0, "ld0");
    step(1'b0, 1'b1, 3, "ld_at_zero");

    // Mid-count asynchronous reset.
    do_reset("rst_c");
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 0, "hundred");
    do_reset("rst_mid");
    step(1'b1, 1'b0, 0, "resume");
    check_eq("resume.x", 32'(x), 32'd229);

    // Randomized traffic with frequent small reloads.
    for (int i = 0; i < 3000; i++) begin
      bit sel;
      bit ld;
      int lsz;
      sel = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 39) == 0);
      lsz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 20));
      step(sel, ld, lsz, "rand");
      if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
    end

`ifdef DRAIN_CHECK_EN
    // Corrupt y for one edge and confirm the sticky flag.
    do_reset("rst_err");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, "pre_force");
    @(negedge clk);
    selector = 1'b0;
    force dut.y_q = WIDTH'(m_steps + 1);
    @(posedge clk);
    #1;
    release dut.y_q;
    check_eq("force.err", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      selector = 1'b1;
      @(posedge clk);
      #1;
      check_eq("sticky.err", 32'(err), 32'd1);
    end
    do_reset("rst_clear_err");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
